// File: rtl/line_clear.sv
// line_clear: after a piece lands, scans the board RAM bottom-up, removes
// every completely filled row and reports how many rows were removed.
// The row above each full row is shifted down, cell by cell, and row 0 is
// cleared. This block owns the RAM interface while busy.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   enable         level request; sampled only in IDLE and DONE
//   ram_rdata      RAM read data, valid the cycle after ram_addr
//   ram_addr       RAM address = row*BOARD_W + col
//   ram_wdata      RAM write data
//   ram_wren       RAM write enable
//   busy           high in every state except IDLE and DONE
//   rows_cleared   full rows removed in the last run (saturates at BOARD_H)
//   complete       one-cycle pulse when the run finishes
module line_clear #(
    parameter int unsigned BOARD_W  = 10,
    parameter int unsigned BOARD_H  = 20,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned COLOUR_W = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [COLOUR_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [COLOUR_W-1:0] ram_wdata,
    output logic                ram_wren,
    output logic                busy,
    output logic [4:0]          rows_cleared,
    output logic                complete
);

    localparam int unsigned ROW_W = 5;
    localparam int unsigned COL_W = 4;
    localparam int unsigned CNT_W = 5;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(BOARD_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(BOARD_H - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(BOARD_H);
    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(BOARD_W);

    typedef enum logic [2:0] {
        IDLE,
        SCAN_A,
        SCAN_D,
        SHIFT_RD,
        SHIFT_WR,
        CLR_TOP,
        DONE
    } state_t;

    state_t             state, state_d;
    logic [ROW_W-1:0]   row, row_d;
    logic [COL_W-1:0]   col, col_d;
    logic [ROW_W-1:0]   src_row, src_row_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               wren_d;
    logic               busy_d;
    logic               complete_d;

    // Linear cell address, computed at ADDR_W width.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        return ADDR_W'(r) * W_A + ADDR_W'(c);
    endfunction

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            src_row      <= '0;
            rows_cleared <= '0;
            ram_addr     <= '0;
            ram_wren     <= 1'b0;
            busy         <= 1'b0;
            complete     <= 1'b0;
        end else begin
            state        <= state_d;
            row          <= row_d;
            col          <= col_d;
            src_row      <= src_row_d;
            rows_cleared <= cnt_d;
            ram_addr     <= addr_d;
            ram_wren     <= wren_d;
            busy         <= busy_d;
            complete     <= complete_d;
        end
    end

    // Next state and counters; outputs are decoded from the next state so the
    // registered RAM address lines up with the state that presents it.
    always_comb begin
        state_d    = state;
        row_d      = row;
        col_d      = col;
        src_row_d  = src_row;
        cnt_d      = rows_cleared;
        addr_d     = '0;
        wren_d     = 1'b0;
        busy_d     = 1'b0;
        complete_d = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    row_d   = ROW_LAST;
                    col_d   = '0;
                    cnt_d   = '0;
                    state_d = SCAN_A;
                end
            end
            SCAN_A: state_d = SCAN_D;
            SCAN_D: begin
                if (ram_rdata == '0) begin
                    // First empty cell ends the scan of this row.
                    if (row == '0) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row - ROW_W'(1);
                        col_d   = '0;
                        state_d = SCAN_A;
                    end
                end else if (col == COL_LAST) begin
                    cnt_d     = (rows_cleared == CNT_MAX) ? rows_cleared
                                                          : rows_cleared + CNT_W'(1);
                    src_row_d = row;
                    col_d     = '0;
                    // Nothing lies above row 0, so only the clear is needed.
                    state_d   = (row == '0) ? CLR_TOP : SHIFT_RD;
                end else begin
                    col_d   = col + COL_W'(1);
                    state_d = SCAN_A;
                end
            end
            SHIFT_RD: state_d = SHIFT_WR;
            SHIFT_WR: begin
                if (col == COL_LAST) begin
                    col_d = '0;
                    if (src_row == ROW_W'(1)) begin
                        state_d = CLR_TOP;
                    end else begin
                        src_row_d = src_row - ROW_W'(1);
                        state_d   = SHIFT_RD;
                    end
                end else begin
                    col_d   = col + COL_W'(1);
                    state_d = SHIFT_RD;
                end
            end
            CLR_TOP: begin
                if (col == COL_LAST) begin
                    // Row is unchanged: rescan the row that just shifted in.
                    col_d   = '0;
                    state_d = SCAN_A;
                end else begin
                    col_d = col + COL_W'(1);
                end
            end
            DONE: begin
                if (!enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            SCAN_A:   addr_d = cell_addr(row_d, col_d);
            SHIFT_RD: addr_d = cell_addr(src_row_d - ROW_W'(1), col_d);
            SHIFT_WR: begin
                addr_d = cell_addr(src_row_d, col_d);
                wren_d = 1'b1;
            end
            CLR_TOP: begin
                addr_d = ADDR_W'(col_d);
                wren_d = 1'b1;
            end
            default: addr_d = '0;
        endcase

        busy_d     = (state_d != IDLE) && (state_d != DONE);
        complete_d = (state_d == DONE) && (state != DONE);
    end

    // Moved cells pass straight through from the read issued in SHIFT_RD;
    // CLR_TOP and all other states write/drive zero.
    assign ram_wdata = (state == SHIFT_WR) ? ram_rdata : '0;

endmodule

// File: tb/tb_line_clear.sv
// Testbench for line_clear: RAM model, row-level reference model and a
// scoreboard that checks each run when complete pulses.
module tb_line_clear;

    localparam int W     = 10;
    localparam int H     = 20;
    localparam int AW    = 8;
    localparam int CW    = 6;
    localparam int CELLS = W * H;

    typedef logic [CELLS*CW-1:0] board_t;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable  = 1'b0;
    logic [CW-1:0] ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [CW-1:0] ram_wdata;
    logic          ram_wren;
    logic          busy;
    logic [4:0]    rows_cleared;
    logic          complete;

    always #5 clk = ~clk;

    line_clear #(.BOARD_W(W), .BOARD_H(H), .ADDR_W(AW), .COLOUR_W(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .ram_rdata    (ram_rdata),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_wren     (ram_wren),
        .busy         (busy),
        .rows_cleared (rows_cleared),
        .complete     (complete)
    );

    // Synchronous RAM with one-cycle read latency and a bulk image load.
    logic [CW-1:0] mem [256];
    logic [CW-1:0] img [256];
    logic          load = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    int n_cmp = 0;
    int n_err = 0;
    int completes = 0;
    int busy_cyc = 0;
    int wr_cyc = 0;

    int     q_rows[$];
    int     q_cyc[$];
    int     q_wr[$];
    board_t q_board[$];

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] get_cell(input board_t b, input int r, input int c);
        return b[(r*W + c)*CW +: CW];
    endfunction

    function automatic bit row_full(input board_t b, input int r);
        for (int c = 0; c < W; c++) if (get_cell(b, r, c) == '0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic board_t ram_image();
        board_t b;
        for (int i = 0; i < CELLS; i++) b[i*CW +: CW] = mem[i];
        return b;
    endfunction

    // Reference: final board = surviving rows packed to the bottom in order,
    // empty rows on top. Cost follows the timing rules per row: 2 cycles per
    // cell read up to the first empty cell; a full row costs W reads, then
    // 2 cycles per moved cell for every row above it, then W clears.
    task automatic model(input board_t b, output board_t o, output int n,
                         output int cyc, output int wr);
        board_t w;
        int dst, r;
        o   = '0;
        n   = 0;
        dst = H - 1;
        for (int rr = H - 1; rr >= 0; rr--) begin
            if (row_full(b, rr)) begin
                n++;
            end else begin
                for (int c = 0; c < W; c++) o[(dst*W + c)*CW +: CW] = get_cell(b, rr, c);
                dst--;
            end
        end
        if (n > H) n = H;
        w   = b;
        r   = H - 1;
        cyc = 0;
        wr  = 0;
        for (int guard = 0; guard < 1000; guard++) begin
            int k;
            k = W;
            for (int c = W - 1; c >= 0; c--) if (get_cell(w, r, c) == '0) k = c;
            if (k == W) begin
                cyc += 2*W + 2*W*r + W;
                wr  += W*r + W;
                for (int rr = r; rr > 0; rr--)
                    for (int c = 0; c < W; c++)
                        w[(rr*W + c)*CW +: CW] = get_cell(w, rr - 1, c);
                for (int c = 0; c < W; c++) w[c*CW +: CW] = '0;
            end else begin
                cyc += 2*(k + 1);
                if (r == 0) break;
                r--;
            end
        end
    endtask

    // Monitor: count busy and write cycles; on complete, score the run.
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cyc = 0;
            wr_cyc   = 0;
        end else begin
            if (busy)     busy_cyc++;
            if (ram_wren) wr_cyc++;
            if (complete) begin
                completes++;
                if (q_rows.size() == 0) begin
                    check("unexpected_complete", completes, completes - 1);
                end else begin
                    board_t eb, ab;
                    int diffs;
                    eb = q_board.pop_front();
                    ab = ram_image();
                    diffs = 0;
                    for (int i = 0; i < CELLS; i++)
                        if (ab[i*CW +: CW] !== eb[i*CW +: CW]) diffs++;
                    check("rows_cleared", rows_cleared, q_rows.pop_front());
                    check("busy_cycles", busy_cyc, q_cyc.pop_front());
                    check("write_cycles", wr_cyc, q_wr.pop_front());
                    check("board_cells_differing", diffs, 0);
                end
                busy_cyc = 0;
                wr_cyc   = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_board(input board_t b);
        for (int i = 0; i < 256; i++) img[i] = (i < CELLS) ? b[i*CW +: CW] : '0;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic run(input board_t b, input int hold);
        board_t o;
        int n, c, w, start;
        load_board(b);
        model(b, o, n, c, w);
        q_rows.push_back(n);
        q_cyc.push_back(c);
        q_wr.push_back(w);
        q_board.push_back(o);
        start  = completes;
        enable = 1'b1;
        for (int i = 0; i < 20000 && completes == start; i++) tick();
        if (completes == start) begin
            check("run_timeout", completes - start, 1);
            void'(q_rows.pop_back());
            void'(q_cyc.pop_back());
            void'(q_wr.pop_back());
            void'(q_board.pop_back());
        end
        for (int i = 0; i < hold; i++) tick();
        check("single_complete", completes - start, 1);
        check("busy_after_done", busy, 0);
        check("complete_held_low", complete, 0);
        enable = 1'b0;
        tick();
        tick();
    endtask

    function automatic board_t fill_row(input board_t b, input int r, input logic [CW-1:0] v);
        board_t t = b;
        for (int c = 0; c < W; c++) t[(r*W + c)*CW +: CW] = v;
        return t;
    endfunction

    function automatic board_t rand_board();
        board_t b = '0;
        for (int r = 0; r < H; r++) begin
            int sel;
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                for (int c = 0; c < W; c++) b[(r*W + c)*CW +: CW] = CW'($urandom_range(1, 63));
            end else if (sel != 1) begin
                for (int c = 0; c < W; c++)
                    b[(r*W + c)*CW +: CW] = ($urandom_range(0, 2) == 0) ? '0 : CW'($urandom_range(1, 63));
                b[(r*W + $urandom_range(0, W - 1))*CW +: CW] = '0;
            end
        end
        return b;
    endfunction

    initial begin
        board_t b;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_wren", ram_wren, 0);
        check("reset_complete", complete, 0);
        check("reset_rows_cleared", rows_cleared, 0);
        check("reset_addr", ram_addr, 0);
        reset_n = 1'b1;
        tick();

        // Empty board: 40 scan cycles, no writes.
        run('0, 1);

        // Row 19 full, row 18 has one cell.
        b = fill_row('0, 19, 6'd5);
        b[(18*W + 3)*CW +: CW] = 6'd2;
        run(b, 1);

        // Rows 19 and 17 full, row 18 has col 0.
        b = fill_row('0, 19, 6'd9);
        b = fill_row(b, 17, 6'd4);
        b[(18*W + 0)*CW +: CW] = 6'd7;
        run(b, 1);

        // Only row 0 full: shift is skipped.
        run(fill_row('0, 0, 6'd33), 1);

        // Whole board full, then hold enable high after complete.
        b = '0;
        for (int r = 0; r < H; r++) b = fill_row(b, r, CW'(r + 1));
        run(b, 20);

        // New run after re-enable: counter restarts from zero.
        b = '0;
        b[(19*W + 4)*CW +: CW] = 6'd1;
        run(b, 1);

        for (int t = 0; t < 8; t++) run(rand_board(), 1);

        // Reset while the first shift write is on the bus.
        load_board(fill_row(rand_board(), 19, 6'd12));
        enable = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ram_wren) break;
        end
        check("reach_shift_write", ram_wren, 1);
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        check("midrun_reset_busy", busy, 0);
        check("midrun_reset_wren", ram_wren, 0);
        check("midrun_reset_complete", complete, 0);
        check("midrun_reset_rows_cleared", rows_cleared, 0);
        check("midrun_reset_wdata", ram_wdata, 0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("idle_after_reset", busy, 0);

        check("leftover_expectations", q_rows.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
